// File: rtl/shift_left_pipelined.sv
// Pipelined logarithmic left shifter: stage k shifts by 2^k when amt[k] is set,
// with zero fill or rotate chosen per beat, and valid/ready on both sides.
module shift_left_pipelined #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic                       in_rot,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data
);

  localparam int unsigned AMT_W = $clog2(WIDTH);

  logic [AMT_W-1:0] r_valid;
  logic [WIDTH-1:0] r_data [AMT_W];
  logic [AMT_W-1:0] r_amt  [AMT_W];
  logic [AMT_W-1:0] r_rot;

  logic [AMT_W-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [AMT_W];
  logic [AMT_W-1:0] w_src_amt  [AMT_W];
  logic [AMT_W-1:0] w_src_rot;
  logic [WIDTH-1:0] w_shift    [AMT_W];
  logic [AMT_W-1:0] w_adv;
  logic             w_run;

  // Upstream view of each stage and the value it would load
  always_comb begin
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
    w_src_amt[0]   = in_amt;
    w_src_rot[0]   = in_rot;
    for (int unsigned k = 1; k < AMT_W; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_amt[k]   = r_amt[k-1];
      w_src_rot[k]   = r_rot[k-1];
    end
    for (int unsigned k = 0; k < AMT_W; k++) begin
      w_shift[k] = w_src_data[k];
      if (w_src_amt[k][k]) begin
        if (w_src_rot[k]) begin
          w_shift[k] = (w_src_data[k] << (32'd1 << k)) |
                       (w_src_data[k] >> (WIDTH - (32'd1 << k)));
        end else begin
          w_shift[k] = w_src_data[k] << (32'd1 << k);
        end
      end
    end
  end

  // Bubble-collapsing advance: a stage moves if it is empty or everything below it moves
  always_comb begin
    w_adv = '0;
    w_run = out_ready;
    for (int unsigned i = 0; i < AMT_W; i++) begin
      w_run = w_run | ~r_valid[AMT_W-1-i];
      w_adv[AMT_W-1-i] = w_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_rot   <= '0;
      for (int unsigned k = 0; k < AMT_W; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < AMT_W; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= w_src_valid[k];
          if (w_src_valid[k]) begin
            r_data[k] <= w_shift[k];
            r_amt[k]  <= w_src_amt[k];
            r_rot[k]  <= w_src_rot[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[AMT_W-1];
  assign out_data  = r_data[AMT_W-1];

endmodule

// File: tb/tb_shift_left_pipelined.sv
// Directed and random scoreboard bench for shift_left_pipelined (WIDTH=16).
module tb_shift_left_pipelined;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    in_amt;
  logic          in_rot;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;
  logic [W-1:0] q [$];

  shift_left_pipelined #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_rot(in_rot),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-by-bit reference: bit i lands at i+amt, wrapping only in rotate mode
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [3:0] a,
                                         input logic r);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < int'(W); i++) begin
      int j;
      j = i + int'(a);
      if (j < int'(W)) res[j] = d[i];
      else if (r) res[j-int'(W)] = d[i];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", 32'(out_data), 32'(q.pop_front()));
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_amt, in_rot));
        n_in++;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [3:0] a, input logic r);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_amt = a; in_rot = r;
    #1;
    while (!in_ready && n < 100) begin step(); n++; end
    chk("send_timeout", 32'(n < 100), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [W-1:0] d, input logic [3:0] a,
                      input logic r, input logic [W-1:0] exp);
    int n;
    send(d, a, r);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk(tag, 32'(out_data), 32'(exp));
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin step(); n++; end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    int acc;
    int base;
    logic [W-1:0] held;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_rot = 1'b0;
    out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency with the extreme amount
    in_valid = 1'b1; in_data = 16'h0001; in_amt = 4'd15; in_rot = 1'b0;
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    chk("latency", 32'(cyc), 32'd4);
    chk("amt15_logical", 32'(out_data), 32'h8000);
    step();

    run1("lsl_1", 16'h8001, 4'd1, 1'b0, 16'h0002);
    run1("rol_1", 16'h8001, 4'd1, 1'b1, 16'h0003);
    run1("rol_4", 16'h1234, 4'd4, 1'b1, 16'h2341);
    run1("rol_8", 16'hF00F, 4'd8, 1'b1, 16'h0FF0);
    run1("lsl_0", 16'hABCD, 4'd0, 1'b0, 16'hABCD);
    run1("rol_0", 16'hABCD, 4'd0, 1'b1, 16'hABCD);
    run1("rol_15", 16'h8001, 4'd15, 1'b1, 16'hC000);
    drain();

    // Backpressure: only four beats fit
    out_ready = 1'b0;
    base = n_out;
    acc = 0;
    in_valid = 1'b1; in_data = 16'h0001; in_rot = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_amt = 4'(acc);
      #1;
      if (in_ready) acc++;
      step();
    end
    in_amt = 4'(acc);
    #1;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_data), 32'h0001);
    held = out_data;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_stable_data", 32'(out_data), 32'(held));
      chk("bp_stable_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    cyc = 0;
    while (acc < 6 && cyc < 50) begin
      in_amt = 4'(acc);
      #1;
      if (in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(n_out - base), 32'd6);

    // Bubble collapse: one beat parks at the output, three more still fit
    out_ready = 1'b0;
    send(16'h0101, 4'd2, 1'b0);
    step(); step(); step();
    chk("bubble_head_valid", 32'(out_valid), 32'd1);
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("bubble_in_ready", 32'(in_ready), 32'd1);
      send(16'h00F0 + 16'(b), 4'(b + 3), 1'(b));
    end
    #1;
    chk("bubble_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    drain();

    // Full throughput: 8 back-to-back beats, 8 consecutive results
    out_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      in_valid = (c < 8);
      in_data = 16'h1111 * 16'(c + 1); in_amt = 4'(c * 2); in_rot = 1'(c);
      #1;
      if (c < 8) chk("tp_in_ready", 32'(in_ready), 32'd1);
      chk("tp_out_valid", 32'(out_valid), 32'((c >= 4) && (c <= 11)));
      step();
    end
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 9) < 8) begin
        in_valid = 1'b1;
        in_data = 16'($urandom);
        in_amt = 4'($urandom_range(0, 15));
        in_rot = 1'($urandom_range(0, 1));
      end
      #1;
      if (in_valid && in_ready) begin
        acc++;
        step();
        in_valid = 1'b0;
      end else begin
        step();
      end
      cyc++;
    end
    chk("rand_sent", 32'(acc), 32'd1000);
    out_ready = 1'b1;
    drain();
    chk("rand_count", 32'(n_out), 32'(n_in));

    // Reset mid-operation discards in-flight beats and refuses the reset-cycle input
    out_ready = 1'b0;
    send(16'h0003, 4'd1, 1'b0);
    send(16'h0005, 4'd2, 1'b1);
    send(16'h0007, 4'd3, 1'b0);
    base = n_out;
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h5555; in_amt = 4'd1; in_rot = 1'b0;
    step();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("midrst_no_output", 32'(n_out - base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_left_pipelined.md
Name: shift_left_pipelined

Overview:
- Pipelined logarithmic left shifter. It is the left-direction counterpart of the team's combinational right shifter.
- One registered stage per shift-amount bit: stage k shifts by 2^k when amt[k] is set.
- Supports logical left shift (zero fill) and rotate left.
- Valid/ready handshake on both sides, so it sits between streaming datapath blocks with backpressure.

Parameters:
- WIDTH, 16, data width in bits; must be a power of 2, at least 2.
- AMT_W, $clog2(WIDTH), shift-amount width and pipeline depth. Derived; must not be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount, 0..WIDTH-1.
- in_rot  input  1  0 = logical left shift (zero fill); 1 = rotate left.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Pipeline structure:
  - AMT_W register stages S0..S(AMT_W-1).
  - Each stage holds: valid bit, data, remaining amount bits, rot flag.
- Stage k operation on load:
  - If amt[k]=1: data << 2^k. Logical mode zero-fills the low 2^k bits. Rotate mode moves the top 2^k bits into the low 2^k bits.
  - If amt[k]=0: data passes unchanged.
- S0 loads from the input port. Sk loads from S(k-1). out_* is driven directly from S(AMT_W-1) registers; there is no extra output register.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_valid = S(AMT_W-1).valid.
- Stage advance rule, per stage, bubble-collapsing:
  - adv(last) = !valid(last) | out_ready.
  - adv(k) = !valid(k) | adv(k+1).
  - in_ready = adv(0). It is combinational from out_ready through the valid chain. No combinational path runs from in_valid or in_data to any output.
- Stage load when adv(k) is true:
  - Sk.valid <= valid of the upstream stage (in_valid for S0).
  - Data, amount and rot are updated only when the upstream stage is valid. Otherwise these fields hold; their content is don't-care.
- Stage hold when adv(k) is false: all Sk fields hold their value.
- Latency and throughput:
  - Latency is exactly AMT_W cycles from input transfer to out_valid when there is no backpressure (4 cycles at WIDTH=16).
  - Throughput is 1 beat per cycle.
- Ordering: results leave in acceptance order. No beat is dropped or duplicated under any out_ready pattern.
- Capacity:
  - Up to AMT_W beats in flight.
  - With out_ready=0 held, in_ready deasserts once all stages are valid.
  - Bubbles collapse: a stalled output does not block upstream stages while empty stages exist downstream.
- Out_data stability: while out_valid=1 and out_ready=0, out_data must stay stable.
- Reset values (synchronous, active-high):
  - All stage valid bits = 0, all stage data = 0. Hence out_valid=0 and out_data=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats.
  - An input presented in the same cycle as rst=1 is not accepted.
- Boundary conditions:
  - amt=0 passes data unchanged in both modes.
  - amt=WIDTH-1 in logical mode leaves only bit 0 of the operand, moved to the MSB.
  - Rotate by any amount preserves the popcount.
  - rot is carried per beat, so mixed-mode back-to-back beats are legal.

Test Plan:
- Latency and extreme amount: rst, then in_data=0x0001, amt=15, rot=0, out_ready=1 → out_valid exactly 4 cycles later with out_data=0x8000. Then 0x8001, amt=1, rot=0 → 0x0002.
- Rotate: 0x8001, amt=1, rot=1 → 0x0003. 0x1234, amt=4, rot=1 → 0x2341. 0xF00F, amt=8, rot=1 → 0x0FF0. 0xABCD, amt=0, either mode → 0xABCD.
- Backpressure: out_ready=0, drive 6 back-to-back beats (0x0001, amt=0..5) → exactly 4 accepted, then in_ready=0. Release out_ready → results 0x0001, 0x0002, 0x0004, 0x0008, 0x0010, 0x0020 in order. out_data stable while stalled.
- Bubble collapse: accept 1 beat with out_ready=0 → it reaches S3; in_ready stays 1 for the next 3 beats while empty stages remain.
- Full throughput and random check: 1000 random beats (random data, amt, rot) with random out_ready toggling → every result matches a reference model, in order, count equal. Back-to-back at out_ready=1 yields 1 result per cycle.
- Reset mid-operation: 3 beats in flight, assert rst for 1 cycle → out_valid=0 and out_data=0 next cycle, none of the 3 beats ever appear. A beat with in_valid=1 during rst is not accepted; in_ready=1 after release.
